seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the 6-digit multiplexed common-cathode display driver.
- Samples the scanned an/sseg bus, identifies which digit is selected, and inverts the 7-segment encoding back to a 4-bit hex value plus decimal point.
- Reassembles complete 6-digit frames and presents them atomically with a one-cycle frame strobe.
- Used for loopback self-test on the board and as a scoreboard monitor in display testbenches.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_scan_decoder_if.sv | 12 +
 rtl/seg7_to_hex.sv | 36 +++
 rtl/seg_scan_decoder.sv | 176 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display driver and scan decoder.
// Segment table, state encoding, digit count and blank select.
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [NUM_DIGITS-1:0] AN_BLANK = 6'b111111;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scanned display bus: active-low digit select plus segment/dp byte.
// The driver side is master, the decoder side is slave.
interface seg_scan_decoder_if;
    import seg_pkg::*;

    logic [NUM_DIGITS-1:0] an_in;
    logic [7:0]            sseg_in;

    modport master (output an_in, output sseg_in);
    modport slave  (input an_in, input sseg_in);

endinterface

// File: rtl/seg7_to_hex.sv
// Inverse 7-segment lookup: pattern to hex nibble.
// valid is low for patterns outside the hex table (hex reads 0).
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       valid
);

    // table lookup, unknown patterns flagged
    always_comb begin
        hex   = 4'h0;
        valid = 1'b1;
        case (seg)
            SEG_0:   hex = 4'h0;
            SEG_1:   hex = 4'h1;
            SEG_2:   hex = 4'h2;
            SEG_3:   hex = 4'h3;
            SEG_4:   hex = 4'h4;
            SEG_5:   hex = 4'h5;
            SEG_6:   hex = 4'h6;
            SEG_7:   hex = 4'h7;
            SEG_8:   hex = 4'h8;
            SEG_9:   hex = 4'h9;
            SEG_A:   hex = 4'hA;
            SEG_B:   hex = 4'hB;
            SEG_C:   hex = 4'hC;
            SEG_D:   hex = 4'hD;
            SEG_E:   hex = 4'hE;
            SEG_F:   hex = 4'hF;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the 6-digit scanned display: rebuilds whole frames.
// Optional stall watchdog enabled by defining SCAN_TIMEOUT_EN.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYC  = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_decoder_if.slave     bus,
    output logic [3:0]            hex0,
    output logic [3:0]            hex1,
    output logic [3:0]            hex2,
    output logic [3:0]            hex3,
    output logic [3:0]            hex4,
    output logic [3:0]            hex5,
    output logic [NUM_DIGITS-1:0] dp_out,
    output logic                  frame_valid,
    output logic                  locked,
    output logic                  pat_err,
    output logic                  seq_err
);

    if (STABLE_CYC < 1 || STABLE_CYC > 15 ||
        TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_param_chk
        $error("seg_scan_decoder: parameter out of range");
    end

    localparam logic [3:0] STB = 4'(STABLE_CYC);

    logic [NUM_DIGITS-1:0] s_an, p_an;
    logic [7:0]            s_sseg, p_sseg;
    logic [3:0]            cnt_q, cnt_cur;
    logic [2:0]            n_zero, k, exp_d;
    logic                  is_sel, is_multi, is_blank;
    logic                  changed, accept, capture;
    logic                  timeout;
    logic [3:0]            dec_hex;
    logic                  dec_ok;
    state_t                state;
    logic [3:0]            sh_hex [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sh_dp;

    seg7_to_hex u_dec (
        .seg   (s_sseg[6:0]),
        .hex   (dec_hex),
        .valid (dec_ok)
    );

    // count active selects and remember which digit is driven
    always_comb begin
        n_zero = '0;
        k      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!s_an[i]) begin
                n_zero = n_zero + 3'd1;
                k      = 3'(i);
            end
        end
    end

    assign is_sel   = (n_zero == 3'd1);
    assign is_multi = (n_zero >= 3'd2);
    assign is_blank = (s_an == AN_BLANK);
    assign changed  = ({s_an, s_sseg} != {p_an, p_sseg});
    assign cnt_cur  = (changed || is_blank) ? 4'd1 :
                      (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
    // a saturated count repeats the same value; only the first hit accepts
    assign accept   = is_sel && (cnt_cur == STB) &&
                      (changed || cnt_q != cnt_cur);
    assign capture  = accept &&
                      (k == 3'd0 || (state == COLLECT && k == exp_d));

`ifdef SCAN_TIMEOUT_EN
    logic [15:0] idle_q;

    assign timeout = (state == COLLECT) && !accept &&
                     (idle_q == 16'(TIMEOUT_CYC - 1));

    // idle cycles since the last accepted digit while collecting
    always_ff @(posedge clk) begin
        if (!rst_n || state != COLLECT || accept)
            idle_q <= '0;
        else
            idle_q <= idle_q + 16'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    // input register stage and stability counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_an   <= AN_BLANK;
            s_sseg <= '0;
            p_an   <= AN_BLANK;
            p_sseg <= '0;
            cnt_q  <= '0;
        end else begin
            s_an   <= bus.an_in;
            s_sseg <= bus.sseg_in;
            p_an   <= s_an;
            p_sseg <= s_sseg;
            cnt_q  <= cnt_cur;
        end
    end

    // frame assembly FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HUNT;
            exp_d       <= '0;
            sh_dp       <= '0;
            for (int i = 0; i < NUM_DIGITS; i++)
                sh_hex[i] <= '0;
            hex0        <= '0;
            hex1        <= '0;
            hex2        <= '0;
            hex3        <= '0;
            hex4        <= '0;
            hex5        <= '0;
            dp_out      <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            pat_err     <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            seq_err     <= 1'b0;
            if (capture) begin
                sh_hex[k] <= dec_hex;
                sh_dp[k]  <= s_sseg[7];
                if (k == 3'd0)
                    pat_err <= !dec_ok;
                else if (!dec_ok)
                    pat_err <= 1'b1;
            end
            if (is_multi || timeout) begin
                seq_err <= 1'b1;
                locked  <= 1'b0;
                state   <= HUNT;
            end else if (accept) begin
                if (state == HUNT) begin
                    if (k == 3'd0) begin
                        exp_d <= 3'd1;
                        state <= COLLECT;
                    end
                end else if (k == exp_d) begin
                    if (k == 3'd5) begin
                        hex0        <= sh_hex[0];
                        hex1        <= sh_hex[1];
                        hex2        <= sh_hex[2];
                        hex3        <= sh_hex[3];
                        hex4        <= sh_hex[4];
                        hex5        <= dec_hex;
                        dp_out      <= {s_sseg[7], sh_dp[4:0]};
                        frame_valid <= 1'b1;
                        locked      <= 1'b1;
                        exp_d       <= 3'd0;
                    end else begin
                        exp_d <= k + 3'd1;
                    end
                end else begin
                    seq_err <= 1'b1;
                    locked  <= 1'b0;
                    if (k == 3'd0)
                        exp_d <= 3'd1;
                    else
                        state <= HUNT;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised scan stimulus against a frame-level reference model.
// Build with SCAN_TIMEOUT_EN to exercise the stall watchdog.
module tb_seg_scan_decoder;

    localparam int ST = 3;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [5:0] dp_out;
    logic       frame_valid, locked, pat_err, seq_err;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(
        .STABLE_CYC  (ST),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3),
        .hex4        (hex4),
        .hex5        (hex5),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .locked      (locked),
        .pat_err     (pat_err),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;
    int cyc = 0;
    int fv_n = 0, se_n = 0, fv_last = 0, fv_gap = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    // model state: registered view of the bus and frame tracking
    logic [5:0] m_san;
    logic [7:0] m_ssg;
    int         m_run, m_exp, m_idle;
    bit         m_hunt;
    logic [3:0] m_sh [6];
    logic [5:0] m_sdp;
    logic [3:0] m_hex [6];
    logic [5:0] m_dp;
    logic       m_fv, m_lk, m_pe, m_se;

    // reference model: acts on the sample stream one clock at a time
    always @(posedge clk) begin : model
        int nz, k, val;
        bit acc, ok, cap, done, was_col;
        cyc++;
        if (!rst_n) begin
            m_san = 6'h3F; m_ssg = 8'h00; m_run = 0;
            m_exp = 0; m_idle = 0; m_hunt = 1;
            m_sdp = 0; m_dp = 0;
            for (int i = 0; i < 6; i++) begin
                m_sh[i] = 0; m_hex[i] = 0;
            end
            m_fv = 0; m_lk = 0; m_pe = 0; m_se = 0;
        end else begin
            nz = 0; k = 0;
            for (int i = 0; i < 6; i++)
                if (!m_san[i]) begin nz++; k = i; end
            m_fv = 0; m_se = 0;
            was_col = !m_hunt;
            acc = (nz == 1) && (m_run == ST);
            if (nz >= 2) begin
                m_se = 1; m_lk = 0; m_hunt = 1;
            end else if (acc) begin
                ok = 0; val = 0;
                for (int j = 0; j < 16; j++)
                    if (seg_tab[j] == m_ssg[6:0]) begin val = j; ok = 1; end
                cap = 0; done = 0;
                if (m_hunt) begin
                    if (k == 0) begin cap = 1; m_exp = 1; m_hunt = 0; end
                end else if (k == m_exp) begin
                    cap = 1;
                    if (k == 5) done = 1; else m_exp = k + 1;
                end else begin
                    m_se = 1; m_lk = 0;
                    if (k == 0) begin cap = 1; m_exp = 1; end
                    else m_hunt = 1;
                end
                if (cap) begin
                    m_sh[k] = 4'(val);
                    m_sdp[k] = m_ssg[7];
                    if (k == 0) m_pe = !ok;
                    else if (!ok) m_pe = 1;
                end
                if (done) begin
                    for (int i = 0; i < 6; i++) m_hex[i] = m_sh[i];
                    m_dp = m_sdp; m_fv = 1; m_lk = 1; m_exp = 0;
                end
            end
`ifdef SCAN_TIMEOUT_EN
            if (was_col && !acc) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_se = 1; m_lk = 0; m_hunt = 1;
                end
            end else begin
                m_idle = 0;
            end
`endif
            if (bus.an_in == m_san && bus.sseg_in == m_ssg &&
                bus.an_in != 6'h3F)
                m_run++;
            else
                m_run = 1;
            m_san = bus.an_in;
            m_ssg = bus.sseg_in;
        end
    end

    // every-cycle comparison against the model, plus event counters
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hex0", hex0, m_hex[0]);
            chk("hex1", hex1, m_hex[1]);
            chk("hex2", hex2, m_hex[2]);
            chk("hex3", hex3, m_hex[3]);
            chk("hex4", hex4, m_hex[4]);
            chk("hex5", hex5, m_hex[5]);
            chk("dp_out", dp_out, m_dp);
            chk("frame_valid", frame_valid, m_fv);
            chk("locked", locked, m_lk);
            chk("pat_err", pat_err, m_pe);
            chk("seq_err", seq_err, m_se);
            if (frame_valid) begin
                fv_n++; fv_gap = cyc - fv_last; fv_last = cyc;
            end
            if (seq_err) se_n++;
        end
    end

    task automatic drive(input logic [5:0] an, input logic [7:0] ss,
                         input int n);
        bus.an_in   = an;
        bus.sseg_in = ss;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dig(input int k, input logic [3:0] h, input int dw);
        drive(~(6'b000001 << k), {1'b0, seg_tab[h]}, dw);
    endtask

    task automatic scan(input logic [23:0] hv, input logic [5:0] dp,
                        input int dw, input int bad_k);
        logic [6:0] p;
        for (int k = 0; k < 6; k++) begin
            p = (k == bad_k) ? 7'h00 : seg_tab[hv[4*k +: 4]];
            drive(~(6'b000001 << k), {dp[k], p}, dw);
        end
    endtask

    task automatic blank(input int n);
        drive(6'h3F, 8'h00, n);
    endtask

    initial begin : stim
        int fv0, se0, r, dw;
        logic [23:0] hv;
        logic [5:0]  dp, an;
        logic [6:0]  p;
        rst_n = 1'b0;
        bus.an_in = 6'h3F;
        bus.sseg_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        chk("rst_hex0", hex0, 0);
        chk("rst_dp", dp_out, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_seq", seq_err, 0);
        rst_n = 1'b1;

        // loopback 1..6 with dp pattern
        repeat (3) scan(24'h654321, 6'b010100, ST, -1);
        blank(5);
        chk("lb_hex0", hex0, 1);
        chk("lb_hex1", hex1, 2);
        chk("lb_hex2", hex2, 3);
        chk("lb_hex3", hex3, 4);
        chk("lb_hex4", hex4, 5);
        chk("lb_hex5", hex5, 6);
        chk("lb_dp", dp_out, 6'b010100);
        chk("lb_locked", locked, 1);
        chk("lb_period", fv_gap, 6 * ST);
        chk("model_hex3", m_hex[3], 4);
        chk("model_dp", m_dp, 6'b010100);

        // unknown pattern on digit 2, then clean frame
        scan(24'h654321, 6'b010100, ST, 2);
        blank(5);
        chk("pat_hex2", hex2, 0);
        chk("pat_err_set", pat_err, 1);
        chk("model_pat", m_pe, 1);
        scan(24'h654321, 6'b010100, ST, -1);
        blank(5);
        chk("pat_err_clr", pat_err, 0);
        chk("pat_hex2_ok", hex2, 3);

        // out-of-order select 0,1,3
        se0 = se_n;
        dig(0, 4'h1, ST); dig(1, 4'h2, ST); dig(3, 4'h4, ST);
        blank(5);
        chk("ooo_locked", locked, 0);
        chk("ooo_seq_cnt", se_n - se0, 1);
        repeat (2) scan(24'hABCDEF, 6'b000000, ST, -1);
        blank(5);
        chk("rec_locked", locked, 1);
        chk("rec_hex0", hex0, 4'hF);
        chk("rec_hex5", hex5, 4'hA);

        // one-cycle multi-select mid frame
        fv0 = fv_n; se0 = se_n;
        dig(0, 4'h1, ST); dig(1, 4'h2, ST); dig(2, 4'h3, ST);
        drive(6'b111100, {1'b0, seg_tab[3]}, 1);
        dig(3, 4'h4, ST); dig(4, 4'h5, ST); dig(5, 4'h6, ST);
        blank(5);
        chk("multi_fv", fv_n - fv0, 0);
        chk("multi_locked", locked, 0);
        chk("multi_seq_cnt", se_n - se0, 1);
        chk("multi_hold", hex0, 4'hF);

        // dwell shorter than STABLE_CYC never accepts
        fv0 = fv_n;
        repeat (3) scan(24'h123456, 6'b111111, ST - 1, -1);
        blank(5);
        chk("short_fv", fv_n - fv0, 0);
        fv0 = fv_n;
        repeat (2) scan(24'h123456, 6'b111111, ST, -1);
        blank(5);
        chk("full_fv", fv_n - fv0, 2);
        chk("full_hex0", hex0, 6);

        // stalled scan after lock
        se0 = se_n;
        blank(TO + 6);
`ifdef SCAN_TIMEOUT_EN
        chk("to_locked", locked, 0);
        chk("to_seq_cnt", se_n - se0, 1);
        chk("to_hold", hex0, 6);
`else
        chk("stall_locked", locked, 1);
        chk("stall_seq_cnt", se_n - se0, 0);
`endif

        // randomised scans with occasional faults
        for (int s = 0; s < 250; s++) begin
            hv = 24'($urandom);
            dp = 6'($urandom);
            for (int k = 0; k < 6; k++) begin
                r = $urandom_range(0, 99);
                if (r < 3) continue;
                p  = (r < 6) ? 7'($urandom) : seg_tab[hv[4*k +: 4]];
                an = (r >= 6 && r < 9) ? 6'($urandom) : ~(6'b000001 << k);
                dw = (r % 10 < 8) ? ST : $urandom_range(1, 5);
                drive(an, {dp[k], p}, dw);
                if ($urandom_range(0, 9) == 0) blank($urandom_range(1, 2));
            end
        end
        blank(5);

        // reset in the middle of a frame
        scan(24'h777777, 6'b101010, ST, -1);
        dig(0, 4'h9, ST); dig(1, 4'h8, ST);
        rst_n = 1'b0;
        blank(2);
        chk("mrst_hex0", hex0, 0);
        chk("mrst_dp", dp_out, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_pat", pat_err, 0);
        rst_n = 1'b1;
        scan(24'h2468AC, 6'b000011, ST, -1);
        blank(5);
        chk("post_hex0", hex0, 4'hC);
        chk("post_dp", dp_out, 6'b000011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
